// File: rtl/countrate_wb_readout.sv
// countrate_wb_readout
//   Control and readout stage placed after the countrate block. It drives
//   window_size, start_counting and reset_counting from host registers.
//   Each count_valid pulse is captured into a snapshot bank. The host reads
//   that bank over a single-clock classic Wishbone slave. Reading COUNT[0]
//   latches a coherent copy of every channel into a read shadow, and the
//   other COUNT[i] registers are served from that shadow.
//
//   Optional feature: define COUNTRATE_READOUT_IRQ_EN to add the irq output
//   port and the writable IRQ_EN bit (CONTROL bit3).
module countrate_wb_readout #(
  parameter int unsigned NUM_OF_CHANNELS = 4,
  parameter int unsigned COUNTER_WIDTH   = 32,
  parameter int unsigned WINDOW_WIDTH    = 64,
  parameter logic [63:0] DEFAULT_WINDOW  = 64'd50000
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_OF_CHANNELS*COUNTER_WIDTH-1:0] count_data,
  input  logic                                     count_valid,
  output logic [WINDOW_WIDTH-1:0]                  window_size,
  output logic                                     start_counting,
  output logic                                     reset_counting,
  input  logic                                     wb_cyc,
  input  logic                                     wb_stb,
  input  logic                                     wb_we,
  input  logic [7:0]                               wb_addr,
  input  logic [31:0]                              wb_data_i,
  output logic [31:0]                              wb_data_o,
`ifdef COUNTRATE_READOUT_IRQ_EN
  output logic                                     irq,
`endif
  output logic                                     wb_ack
);

  localparam int unsigned SNAP_W  = NUM_OF_CHANNELS * COUNTER_WIDTH;
  localparam int unsigned HI_W    = WINDOW_WIDTH - 32;
  localparam logic [31:0] ID_WORD = 32'h43525431;

  // Register word indices, taken from wb_addr[7:2].
  localparam logic [5:0] IDX_ID     = 6'd0;
  localparam logic [5:0] IDX_CTRL   = 6'd1;
  localparam logic [5:0] IDX_STATUS = 6'd2;
  localparam logic [5:0] IDX_WIN_LO = 6'd3;
  localparam logic [5:0] IDX_WIN_HI = 6'd4;
  localparam logic [5:0] IDX_WCOUNT = 6'd5;
  localparam logic [5:0] IDX_COUNT0 = 6'd8;
  localparam logic [6:0] COUNT_END  = 7'(8 + NUM_OF_CHANNELS);

  logic                    wb_ack_r;
  logic [31:0]             wb_data_r;
  logic [WINDOW_WIDTH-1:0] window_r;
  logic                    start_r;
  logic                    reset_r;
  logic                    freeze_r;
  logic                    irq_en_s;
  logic [SNAP_W-1:0]       snap_r;
  logic [SNAP_W-1:0]       shadow_r;
  logic                    snap_valid_r;
  logic                    overrun_r;
  logic [31:0]             window_count_r;

  logic [5:0]  idx_s;
  logic        req_s;
  logic        wr_s;
  logic        rd_s;
  logic        wr_ctrl_s;
  logic        ctrl_reset_s;
  logic        rd_count0_s;
  logic        capture_s;
  logic        snap_valid_next_s;
  logic        overrun_next_s;
  logic [31:0] cnt_word_s;
  logic [31:0] rd_word_s;
  logic        unused_addr_s;

  assign idx_s         = wb_addr[7:2];
  assign unused_addr_s = ^wb_addr[1:0];

  // A new Wishbone request is accepted only when no ack is pending.
  assign req_s        = wb_cyc & wb_stb & ~wb_ack_r;
  assign wr_s         = req_s & wb_we;
  assign rd_s         = req_s & ~wb_we;
  assign wr_ctrl_s    = wr_s & (idx_s == IDX_CTRL);
  assign ctrl_reset_s = wr_ctrl_s & wb_data_i[1];
  assign rd_count0_s  = rd_s & (idx_s == IDX_COUNT0);
  assign capture_s    = count_valid & ~freeze_r;

  // Next status bits: a capture sets bits, W1C clears bits, and set wins on a tie.
  always_comb begin
    snap_valid_next_s = snap_valid_r;
    overrun_next_s    = overrun_r;
    if (wr_s && (idx_s == IDX_STATUS)) begin
      snap_valid_next_s = snap_valid_r & ~wb_data_i[0];
      overrun_next_s    = overrun_r & ~wb_data_i[1];
    end else begin
      snap_valid_next_s = snap_valid_r;
      overrun_next_s    = overrun_r;
    end
    if (capture_s) begin
      snap_valid_next_s = 1'b1;
      overrun_next_s    = overrun_next_s | snap_valid_r;
    end else begin
      snap_valid_next_s = snap_valid_next_s;
      overrun_next_s    = overrun_next_s;
    end
  end

  // COUNT word select: COUNT[0] comes from the live snapshot, the rest from the shadow.
  always_comb begin
    cnt_word_s = 32'd0;
    if (({1'b0, idx_s} >= {1'b0, IDX_COUNT0}) && ({1'b0, idx_s} < COUNT_END)) begin
      if (idx_s == IDX_COUNT0) begin
        cnt_word_s[COUNTER_WIDTH-1:0] = snap_r[COUNTER_WIDTH-1:0];
      end else begin
        cnt_word_s[COUNTER_WIDTH-1:0] =
          shadow_r[int'(idx_s - IDX_COUNT0) * COUNTER_WIDTH +: COUNTER_WIDTH];
      end
    end else begin
      cnt_word_s = 32'd0;
    end
  end

  // Read data multiplexer for the register map.
  always_comb begin
    rd_word_s = 32'd0;
    case (idx_s)
      IDX_ID:     rd_word_s = ID_WORD;
      IDX_CTRL:   rd_word_s = {28'd0, irq_en_s, freeze_r, 2'b00};
      IDX_STATUS: rd_word_s = {24'(NUM_OF_CHANNELS), 6'd0, overrun_r, snap_valid_r};
      IDX_WIN_LO: rd_word_s = window_r[31:0];
      IDX_WIN_HI: begin
        rd_word_s            = 32'd0;
        rd_word_s[HI_W-1:0]  = window_r[WINDOW_WIDTH-1:32];
      end
      IDX_WCOUNT: rd_word_s = window_count_r;
      default:    rd_word_s = cnt_word_s;
    endcase
  end

  // Wishbone handshake: one-cycle ack, and read data that holds until the next read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_ack_r  <= 1'b0;
      wb_data_r <= 32'd0;
    end else begin
      wb_ack_r <= wb_cyc & wb_stb & ~wb_ack_r;
      if (rd_s) begin
        wb_data_r <= rd_word_s;
      end
    end
  end

  // Control registers, the window size and the one-cycle countrate pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      window_r <= DEFAULT_WINDOW[WINDOW_WIDTH-1:0];
      start_r  <= 1'b0;
      reset_r  <= 1'b0;
      freeze_r <= 1'b0;
    end else begin
      start_r <= wr_ctrl_s & wb_data_i[0];
      reset_r <= ctrl_reset_s;
      if (wr_ctrl_s) begin
        freeze_r <= wb_data_i[2];
      end
      if (wr_s && (idx_s == IDX_WIN_LO)) begin
        window_r[31:0] <= wb_data_i;
      end
      if (wr_s && (idx_s == IDX_WIN_HI)) begin
        window_r[WINDOW_WIDTH-1:32] <= wb_data_i[HI_W-1:0];
      end
    end
  end

  // Snapshot capture, shadow copy, status and window counter. A CONTROL reset write overrides a capture on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_r         <= '0;
      shadow_r       <= '0;
      snap_valid_r   <= 1'b0;
      overrun_r      <= 1'b0;
      window_count_r <= 32'd0;
    end else if (ctrl_reset_s) begin
      snap_r         <= '0;
      shadow_r       <= '0;
      snap_valid_r   <= 1'b0;
      overrun_r      <= 1'b0;
      window_count_r <= 32'd0;
    end else begin
      if (count_valid) begin
        window_count_r <= window_count_r + 32'd1;
      end
      if (capture_s) begin
        snap_r <= count_data;
      end
      // The shadow takes the snapshot held before this edge, so a coincident capture is not mixed in.
      if (rd_count0_s) begin
        shadow_r <= snap_r;
      end
      snap_valid_r <= snap_valid_next_s;
      overrun_r    <= overrun_next_s;
    end
  end

`ifdef COUNTRATE_READOUT_IRQ_EN
  logic irq_en_r;
  logic irq_r;

  assign irq_en_s = irq_en_r;
  assign irq      = irq_r;

  // IRQ_EN register and the registered interrupt line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_en_r <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      if (wr_ctrl_s) begin
        irq_en_r <= wb_data_i[3];
      end
      irq_r <= snap_valid_r & irq_en_r;
    end
  end
`else
  assign irq_en_s = 1'b0;
`endif

  assign wb_ack         = wb_ack_r;
  assign wb_data_o      = wb_data_r;
  assign window_size    = window_r;
  assign start_counting = start_r;
  assign reset_counting = reset_r;

endmodule
